// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between the
// instruction-side and data-side cache controllers; single-word transactions.
module memory_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  i_ack,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ack,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  owner
);

  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  we_q;
  logic                  last_owner_q;
  logic                  owner_q;
  logic                  busy_q;
  logic                  i_ack_q;
  logic                  d_ack_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [DATA_WIDTH-1:0] i_rdata_q;
  logic [DATA_WIDTH-1:0] d_rdata_q;

  // Data side wins when it is alone, or when both ask and instruction went last.
  logic grant_d_d;
  always_comb begin
    grant_d_d = d_req && (!i_req || !last_owner_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      last_owner_q <= 1'b0;
      owner_q      <= 1'b0;
      busy_q       <= 1'b0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          i_ack_q  <= 1'b0;
          d_ack_q  <= 1'b0;
          mem_we_q <= 1'b0;
          if (i_req || d_req) begin
            owner_q      <= grant_d_d;
            last_owner_q <= grant_d_d;
            we_q         <= grant_d_d ? d_we : i_we;
            mem_we_q     <= grant_d_d ? d_we : i_we;
            mem_addr_q   <= grant_d_d ? d_addr : i_addr;
            mem_wdata_q  <= grant_d_d ? d_wdata : i_wdata;
            cnt_q        <= CNT_W'(LATENCY - 1);
            busy_q       <= 1'b1;
            state_q      <= BUSY;
          end
        end
        BUSY: begin
          // Write strobe lives only in the first BUSY cycle.
          mem_we_q <= 1'b0;
          if (cnt_q == '0) begin
            if (!we_q) begin
              if (owner_q) d_rdata_q <= mem_rdata;
              else         i_rdata_q <= mem_rdata;
            end
            i_ack_q <= !owner_q;
            d_ack_q <= owner_q;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          i_ack_q <= 1'b0;
          d_ack_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign i_ack     = i_ack_q;
  assign d_ack     = d_ack_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Shared main-memory arbiter between the instruction-side and data-side cache controllers. Each side issues single-word read or write transactions. The arbiter grants one side at a time, drives the single fixed-latency memory port, and returns read data with a one-cycle acknowledge. Round-robin arbitration prevents starvation when both sides contend.

## Interface
- ADDR_WIDTH, 32, memory address width
- DATA_WIDTH, 32, memory word width
- LATENCY, 4, cycles the memory needs with address held stable before read data is valid or a write is committed; must be ≥ 1
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- i_req  in  1  instruction-side request (level)
- i_we  in  1  instruction-side write enable, valid while i_req
- i_addr  in  ADDR_WIDTH  instruction-side address, valid while i_req
- i_wdata  in  DATA_WIDTH  instruction-side write data, valid while i_req
- i_ack  out  1  one-cycle completion pulse to instruction side
- i_rdata  out  DATA_WIDTH  instruction-side read data; valid when i_ack is high and held afterwards
- d_req, d_we, d_addr, d_wdata, d_ack, d_rdata: same as the i_ signals, for the data side
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_we  out  1  memory write strobe
- mem_rdata  in  DATA_WIDTH  memory read data
- busy  out  1  high in BUSY and RESP
- owner  out  1  side of the current or most recent grant: 0 = instruction, 1 = data

## Operation
- States: IDLE, BUSY, RESP. All outputs are registered.
- IDLE
  - Nothing requested: stay in IDLE.
  - Exactly one req high: grant that side.
  - Both req high: grant the side ≠ last_owner.
  - On grant: latch we, addr and wdata of the granted side; set owner and last_owner; load counter with LATENCY−1; go to BUSY.
- BUSY
  - mem_addr and mem_wdata are held from the latched values.
  - mem_we = latched we in the first BUSY cycle only; 0 otherwise.
  - Counter decrements each cycle.
  - At counter = 0:
    - For a read, capture mem_rdata into the owner's rdata register. The other side's rdata register is unchanged.
    - For a write, no rdata register changes.
    - Go to RESP.
- RESP: assert the owner's ack for exactly this cycle; go to IDLE. Both req inputs are ignored in RESP.
- Requester rule: a requester must hold req, we, addr and wdata stable until it sees ack. If its req is still high in the cycle after ack, that starts a new transaction.
- Counter width is clog2(LATENCY+1). The counter never wraps below 0.
- i_ack and d_ack are never high in the same cycle.
- A side whose req drops while it is waiting but not yet granted is simply not served. No error is raised.

## Timing
- Reset values:
  - state = IDLE, last_owner = 0, owner = 0, busy = 0
  - i_ack = d_ack = 0, mem_we = 0
  - mem_addr, mem_wdata, i_rdata, d_rdata = 0
- Cycle numbering: request sampled in IDLE at cycle 0.
  - BUSY in cycles 1..LATENCY; mem_addr valid in cycles 1..LATENCY.
  - mem_we high in cycle 1 only, for a write.
  - mem_rdata sampled at the end of cycle LATENCY.
  - ack in cycle LATENCY+1.
  - IDLE in cycle LATENCY+2, where the next request can be accepted.
- Request-to-ack latency is LATENCY+1 cycles. Peak throughput is one transaction per LATENCY+2 cycles.
- With LATENCY = 1: a single BUSY cycle, in which mem_we is asserted and mem_rdata is sampled.
- Reset asserted in any state, including mid-BUSY or RESP:
  - Next cycle: IDLE, all outputs at reset values.
  - The in-flight transaction is dropped with no ack; the requester reissues it.
- Outside BUSY, mem_addr and mem_wdata hold their last values and mem_we = 0.

## Test plan
- Instruction read, LATENCY=4: i_req=1, i_we=0, i_addr=0x100 at cycle 0; memory returns 0xDEADBEEF → mem_addr=0x100 in cycles 1–4, mem_we never high, i_ack high in cycle 5 only, i_rdata=0xDEADBEEF from cycle 5 on, d_ack stays 0.
- Data write: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0x12345678 → mem_we high in cycle 1 only with mem_addr=0x2000 and mem_wdata=0x12345678; d_ack in cycle 5; d_rdata unchanged.
- Contention after reset: i_req and d_req both high at cycle 0, each dropped after its own ack → data side served first (d_ack cycle 5, owner=1), then instruction side accepted at cycle 6 (i_ack cycle 11, owner=0).
- Sustained contention: both req held high for 4 transactions → grants alternate D, I, D, I; acks at cycles 5, 11, 17, 23.
- Reset mid-transaction: i read started at cycle 0, rst high in cycle 2 → cycle 3 in IDLE, busy=0, no i_ack ever issued; a reissued i_req at cycle 4 completes with i_ack at cycle 9.
- LATENCY=1 single read with a new request on the cycle after ack: d_req held through the ack → d_ack at cycles 2 and 5; mem_rdata sampled in cycles 1 and 4.
